// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: destination scoreboard for DEPTH stages after decode,
// load-use stalls, branch flushes and operand forwarding selects. Optional counters: HAZ_PERF_EN.
module pipe_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    localparam int FSW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rdEn,
    input  logic              id_isLoad,
    input  logic              ex_branch_taken,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [FSW-1:0]    fwd_a_sel,
    output logic [FSW-1:0]    fwd_b_sel,
    output logic [DEPTH-1:0]  stage_valid,
    output logic              stall
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  wen_q;
    logic [DEPTH-1:0]  load_q;
    logic [REG_AW-1:0] rd_q [DEPTH];

    logic [DEPTH-1:0]  hit_rs1;
    logic [DEPTH-1:0]  hit_rs2;
    logic [DEPTH-1:0]  early_mask;
    logic              load_use;
    logic              branch_ok;
    logic              unused_load;

    // Stages still short of the load-data-ready point; a load sitting there cannot forward yet.
    for (genvar g = 0; g < DEPTH; g++) begin : g_early
        assign early_mask[g] = (g < LOAD_STAGE - 1);
    end

    // Load flags past the forwardable point only ride along the shift chain.
    assign unused_load = ^load_q;

    always_comb begin
        hit_rs1 = '0;
        hit_rs2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit_rs1[k] = valid_q[k] & wen_q[k] & (rd_q[k] == id_rs1) & (id_rs1 != '0);
            hit_rs2[k] = valid_q[k] & wen_q[k] & (rd_q[k] == id_rs2) & (id_rs2 != '0);
        end
    end

    // Scanning from the oldest stage down leaves the youngest producer selected.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (id_use_rs1 && hit_rs1[k]) fwd_a_sel = FSW'(k + 1);
            if (id_use_rs2 && hit_rs2[k]) fwd_b_sel = FSW'(k + 1);
        end
    end

    // A taken branch kills the decode instruction, so it overrides any load-use stall.
    always_comb begin
        branch_ok   = ex_branch_taken & valid_q[0];
        load_use    = id_valid &
                      ((id_use_rs1 & |(hit_rs1 & load_q & early_mask)) |
                       (id_use_rs2 & |(hit_rs2 & load_q & early_mask)));
        stall       = load_use & ~branch_ok;
        pc_en       = ~stall;
        ifid_en     = ~stall;
        ifid_flush  = branch_ok;
        idex_bubble = stall | branch_ok;
    end

    assign stage_valid = valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            wen_q   <= '0;
            load_q  <= '0;
            for (int k = 0; k < DEPTH; k++) rd_q[k] <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                valid_q[k] <= valid_q[k-1];
                wen_q[k]   <= wen_q[k-1];
                load_q[k]  <= load_q[k-1];
                rd_q[k]    <= rd_q[k-1];
            end
            if (idex_bubble) begin
                valid_q[0] <= 1'b0;
                wen_q[0]   <= 1'b0;
                load_q[0]  <= 1'b0;
                rd_q[0]    <= '0;
            end else begin
                valid_q[0] <= id_valid;
                wen_q[0]   <= id_rdEn;
                load_q[0]  <= id_isLoad;
                rd_q[0]    <= id_rd;
            end
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall)     perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (branch_ok) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the pipelined RISC-V core.
- Supersedes the fixed single pip_en enable of the two-stage fetch/decode/execute pipeline.
- Tracks destination scoreboard for DEPTH stages downstream of decode. Generates PC/IF-ID enables, bubble/flush controls, load-use stalls and per-operand forwarding selects.
- Sits beside the control unit. Consumes decode-stage fields and the EX-stage branch result.

Parameters:
- REG_AW, 5, register address width (32 architectural registers).
- DEPTH, 3, tracked stages after decode: 1=EX, 2=MEM, ..., DEPTH=WB; legal 2..6.
- LOAD_STAGE, 2, first stage index at which load data is forwardable; legal 1..DEPTH.
- FSW, $clog2(DEPTH+1), forwarding select width (derived; not overridden).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs1  in  REG_AW  decode rs1 address
- id_rs2  in  REG_AW  decode rs2 address
- id_use_rs1  in  1  decode instruction reads rs1
- id_use_rs2  in  1  decode instruction reads rs2
- id_rd  in  REG_AW  decode rd address
- id_rdEn  in  1  decode instruction writes rd
- id_isLoad  in  1  decode instruction is a load
- ex_branch_taken  in  1  EX-stage instruction redirects PC this cycle
- pc_en  out  1  PC may advance
- ifid_en  out  1  IF/ID register may load
- ifid_flush  out  1  IF/ID register loads a bubble
- idex_bubble  out  1  ID/EX register loads a bubble
- fwd_a_sel  out  FSW  rs1 source: 0=regfile, k=stage k result
- fwd_b_sel  out  FSW  rs2 source, same encoding
- stage_valid  out  DEPTH  valid bit per tracked stage, bit k-1 = stage k
- stall  out  1  load-use stall active this cycle

Behaviour:
- Scoreboard: per stage k, registers valid_k, rd_k, wen_k, load_k. Reset clears all to 0; stage_valid=0.
- Comb outputs after reset with id_valid=0: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, fwd sels=0, stall=0.
- Match(k,r): valid_k & wen_k & rd_k==r & r!=0. x0 never matches, never forwards, never stalls.
- Forwarding: fwd_a_sel = smallest k with Match(k,id_rs1) & id_use_rs1, else 0. Youngest producer wins. fwd_b_sel is identical for rs2. Purely combinational, zero latency.
- Load-use: stall=1 when id_valid and either used source matches some k<LOAD_STAGE with load_k=1.
- Stall cycle:
  - pc_en=0, ifid_en=0, idex_bubble=1.
  - Stage 1 loads bubble (valid=0). Stages 2..DEPTH shift normally.
  - Stall lasts exactly LOAD_STAGE-k cycles for a producer at stage k, then releases automatically.
- Branch: ex_branch_taken=1 gives ifid_flush=1, idex_bubble=1, pc_en=1 (PC loads target), ifid_en=1. Stage 1 next cycle = bubble. Branch instruction itself continues to stage 2.
- Branch and stall same cycle: flush wins. stall output forced 0, pc_en=1. The stalled decode instruction is killed.
- Normal advance: stage 1 <= {id_valid, id_rd, id_rdEn, id_isLoad}. Stage k <= stage k-1. Stage DEPTH contents drop off.
- ex_branch_taken with stage_valid[0]=0 is ignored (treated as 0).
- Reset mid-stall or mid-flush: next edge clears all state. No residual stall.

Optional Feature:
- Macro HAZ_PERF_EN. When defined, adds outputs perf_stall_cnt [31:0] and perf_flush_cnt [31:0].
  - perf_stall_cnt increments each stall cycle. perf_flush_cnt increments each accepted branch flush.
  - Both wrap 0xFFFFFFFF->0 and clear on reset.
- When undefined, the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- reset=1 two cycles with random inputs -> stage_valid=000, pc_en=1, fwd sels=0, stall=0.
- addi x5 issued, next decode reads rs1=5 -> fwd_a_sel=1. Following cycle, unrelated ID reading x5 -> fwd_a_sel=2; at stage 3 -> 3.
- lw x7 then add using rs2=7 (LOAD_STAGE=2) -> stall=1 one cycle, pc_en=0, idex_bubble=1. Next cycle stall=0, fwd_b_sel=2.
- Producer rd=0 with rdEn=1, consumer rs1=0 -> fwd_a_sel=0, no stall.
- ex_branch_taken=1 coincident with a load-use stall -> ifid_flush=1, idex_bubble=1, stall=0, pc_en=1. Stage 1 invalid next cycle.
- HAZ_PERF_EN: 3 load-use stalls + 2 branch flushes -> perf_stall_cnt=3, perf_flush_cnt=2. Reset -> both 0.
